// File: rtl/cpu_write_capture.sv
// Captures CPU writes to a 4-entry register page: synchronizes the bus, deglitches M2,
// tracks the bus cycle with a small FSM and commits qualified writes on the falling M2 edge.
module cpu_write_capture #(
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_LEN    = 2,
  parameter logic [3:0]  REG_PAGE    = 4'h5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic        wr_stb,
  output logic [1:0]  wr_sel,
  output logic [3:0]  wr_data,
  output logic [3:0]  reg0,
  output logic [3:0]  reg1,
  output logic [3:0]  reg2,
  output logic [3:0]  reg3
);

  localparam int         BW        = 12;
  localparam logic [1:0] FILT_LAST = 2'(FILT_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, WRITE, COMMIT} state_t;

  // Only the decoded fields travel the sync chain; the rest of the bus is don't-care.
  logic unused_bits;
  assign unused_bits = ^{cpu_addr[11:10], cpu_addr[7:0], cpu_data[7:4]};

  logic [BW-1:0]          sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_q;
  logic [BW-1:0]          s_bus;
  logic                   s_m2, s_rw;
  logic [3:0]             s_page, s_data;
  logic [1:0]             s_sel;

  assign s_bus = sync_q[SYNC_STAGES-1];
  assign {s_m2, s_rw, s_page, s_sel, s_data} = s_bus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      vld_q <= '0;
    end else begin
      sync_q[0] <= {m2, cpu_rw, cpu_addr[15:12], cpu_addr[9:8], cpu_data[3:0]};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  logic       m2f_q, m2f_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       armed_q, armed_d;

  always_comb begin
    m2f_d  = m2f_q;
    fcnt_d = '0;
    if (s_m2 != m2f_q) begin
      if (fcnt_q == FILT_LAST) m2f_d = s_m2;
      else                     fcnt_d = fcnt_q + 2'd1;
    end
    // A cycle already under way at reset release must be seen to end before any rise counts.
    armed_d = armed_q | (vld_q[SYNC_STAGES-1] & ~s_m2 & ~m2f_q);
  end

  state_t     state_q, state_d;
  logic [1:0] cap_sel_q, cap_sel_d;
  logic [3:0] cap_data_q, cap_data_d;
  logic       qual;

  assign qual = ~s_rw & (s_page == REG_PAGE);

  always_comb begin
    state_d    = state_q;
    cap_sel_d  = cap_sel_q;
    cap_data_d = cap_data_q;
    unique case (state_q)
      IDLE:   if (armed_q && m2f_q) state_d = ACTIVE;
      ACTIVE, WRITE: begin
        if (m2f_q) begin
          cap_sel_d  = s_sel;
          cap_data_d = s_data;
          state_d    = qual ? WRITE : ACTIVE;
        end else begin
          state_d = (state_q == WRITE) ? COMMIT : IDLE;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic       stb_q;
  logic [1:0] sel_q;
  logic [3:0] data_q;
  logic [3:0] regs_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2f_q      <= 1'b0;
      fcnt_q     <= '0;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      cap_sel_q  <= '0;
      cap_data_q <= '0;
      stb_q      <= 1'b0;
      sel_q      <= '0;
      data_q     <= '0;
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      m2f_q      <= m2f_d;
      fcnt_q     <= fcnt_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      cap_sel_q  <= cap_sel_d;
      cap_data_q <= cap_data_d;
      stb_q      <= (state_d == COMMIT);
      // Commit results are registered on entry so they are visible for the whole COMMIT clock.
      if (state_d == COMMIT) begin
        sel_q             <= cap_sel_q;
        data_q            <= cap_data_q;
        regs_q[cap_sel_q] <= cap_data_q;
      end
    end
  end

  assign wr_stb  = stb_q;
  assign wr_sel  = sel_q;
  assign wr_data = data_q;
  assign reg0    = regs_q[0];
  assign reg1    = regs_q[1];
  assign reg2    = regs_q[2];
  assign reg3    = regs_q[3];

endmodule

// File: tb/tb_cpu_write_capture.sv
// Bench for cpu_write_capture: directed scenarios plus random bus cycles, checked each clock
// against a transaction-level model (queue of expected commits and a shadow register file).
module tb_cpu_write_capture;

  localparam int S = 2;
  localparam int F = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m2 = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        wr_stb;
  logic [1:0]  wr_sel;
  logic [3:0]  wr_data, reg0, reg1, reg2, reg3;

  cpu_write_capture #(.SYNC_STAGES(S), .FILT_LEN(F), .REG_PAGE(4'h5)) dut (
    .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .wr_stb(wr_stb), .wr_sel(wr_sel), .wr_data(wr_data),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  typedef struct {int sel; int data; int fall;} exp_t;
  exp_t q[$];
  int   mregs[4];
  int   msel = 0, mdata = 0;
  int   n_stb = 0;
  int   first_lat = -1;
  bit   prev_stb = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // mode: 0 write, 1 read, 2 read turning into write, 3 write turning into read
  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input int mode,
                           input int hi, input int lo);
    logic rw0, rw1;
    rw0 = (mode == 1 || mode == 2);
    rw1 = (mode == 1 || mode == 3);
    cpu_addr = a; cpu_data = d; cpu_rw = rw0; m2 = 1'b1;
    tick(hi / 2);
    cpu_rw = rw1;
    tick(hi - hi / 2);
    m2 = 1'b0;
    if (!rw1 && a[15:12] == 4'h5) q.push_back('{int'(a[9:8]), int'(d[3:0]), cyc});
    tick(lo);
  endtask

  function automatic int dut_reg(input int i);
    case (i)
      0: return int'(reg0);
      1: return int'(reg1);
      2: return int'(reg2);
      default: return int'(reg3);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t it;
    int   lat;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mregs[i] = 0;
      msel = 0; mdata = 0; q.delete();
      chk("reset_stb", int'(wr_stb), 0);
      chk("reset_sel", int'(wr_sel), 0);
      chk("reset_data", int'(wr_data), 0);
      for (int i = 0; i < 4; i++) chk($sformatf("reset_reg%0d", i), dut_reg(i), 0);
    end else begin
      if (wr_stb) begin
        n_stb++;
        chk("stb_single_clk", int'(prev_stb), 0);
        if (q.size() == 0) begin
          chk("spurious_stb", 1, 0);
        end else begin
          it = q.pop_front();
          lat = cyc - it.fall;
          if (first_lat < 0) first_lat = lat;
          total++;
          if (lat < S + F || lat > S + F + 2) begin
            bad++;
            $display("FAIL stb_latency: got %0d expected %0d..%0d", lat, S + F, S + F + 2);
          end
          mregs[it.sel] = it.data;
          msel = it.sel; mdata = it.data;
        end
      end
      chk("wr_sel", int'(wr_sel), msel);
      chk("wr_data", int'(wr_data), mdata);
      for (int i = 0; i < 4; i++) chk($sformatf("reg%0d", i), dut_reg(i), mregs[i]);
    end
    prev_stb = wr_stb;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [3:0] page;
    logic [15:0] a;
    tick(3);
    rst_n = 1'b1;
    tick(4);

    // Fill all four registers.
    base = n_stb;
    bus_cycle(16'h5000, 8'h0A, 0, 5, 4);
    bus_cycle(16'h5100, 8'h05, 0, 5, 4);
    bus_cycle(16'h5200, 8'h0C, 0, 5, 4);
    bus_cycle(16'h5300, 8'h07, 0, 5, 4);
    tick(8);
    chk("fill_strobes", n_stb - base, 4);
    chk("fill_reg0", int'(reg0), 10);
    chk("fill_reg1", int'(reg1), 5);
    chk("fill_reg2", int'(reg2), 12);
    chk("fill_reg3", int'(reg3), 7);
    chk("fill_sel", int'(wr_sel), 3);
    chk("first_latency", first_lat, 5);

    // Read and off-page writes never strobe.
    base = n_stb;
    bus_cycle(16'h5200, 8'h03, 1, 5, 4);
    bus_cycle(16'h6000, 8'h0F, 0, 5, 4);
    bus_cycle(16'h8000, 8'h0F, 0, 5, 4);
    tick(8);
    chk("noqual_strobes", n_stb - base, 0);
    chk("noqual_reg2", int'(reg2), 12);

    // One-clock glitch, then a real cycle.
    base = n_stb;
    cpu_addr = 16'h5000; cpu_data = 8'h03; cpu_rw = 1'b0; m2 = 1'b1;
    tick(1);
    m2 = 1'b0;
    tick(5);
    chk("glitch_strobes", n_stb - base, 0);
    bus_cycle(16'h5000, 8'h03, 0, 5, 4);
    tick(8);
    chk("after_glitch_strobes", n_stb - base, 1);
    chk("after_glitch_reg0", int'(reg0), 3);

    // Late write qualifier.
    bus_cycle(16'h5300, 8'h0E, 2, 6, 4);
    tick(8);
    chk("late_rw_reg3", int'(reg3), 14);

    // Reset during WRITE; release while m2 is still high.
    base = n_stb;
    cpu_addr = 16'h5100; cpu_data = 8'h09; cpu_rw = 1'b0; m2 = 1'b1;
    tick(7);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    m2 = 1'b0;
    tick(10);
    chk("abort_strobes", n_stb - base, 0);
    chk("abort_reg1", int'(reg1), 0);

    // Back-to-back writes with short m2 low, then a same-value rewrite.
    base = n_stb;
    bus_cycle(16'h5000, 8'h01, 0, 5, 3);
    bus_cycle(16'h5000, 8'h02, 0, 5, 3);
    tick(8);
    chk("b2b_strobes", n_stb - base, 2);
    chk("b2b_reg0", int'(reg0), 2);
    base = n_stb;
    bus_cycle(16'h5000, 8'h02, 0, 5, 4);
    tick(8);
    chk("rewrite_strobes", n_stb - base, 1);

    // Random traffic including mirrors and mixed qualifiers.
    repeat (60) begin
      case ($urandom_range(0, 3))
        0, 1: page = 4'h5;
        2:    page = 4'h6;
        default: page = 4'($urandom_range(0, 15));
      endcase
      a = {page, 12'($urandom)};
      bus_cycle(a, 8'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(4, 7)), int'($urandom_range(3, 6)));
    end
    tick(10);
    chk("pending_commits", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
